// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and defaults for the instruction prefetch queue.
//               A queue entry bundles an instruction word with its PC and
//               PC+4, so the register stage needs no adder of its own.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  localparam int          FETCH_XLEN        = 32;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] instr;
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_XLEN-1:0] pc_plus_4;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_prefetch_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_prefetch_queue_if
// Description : Bus bundle of the prefetch queue: the fetch side of the shared
//               memory port, the redirect input from the ALU stage and the
//               head-entry handshake towards the register stage.
// Ports       : master - queue view (drives imem_req/addr, out_*, occupancy)
//               slave  - environment view (drives grant, rdata, redirect,
//                        out_ready)
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_prefetch_queue_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);

  localparam int c_occ_w = $clog2(DEPTH + 1);

  // memory port
  logic               imem_req;
  logic [XLEN-1:0]    imem_addr;
  logic               imem_gnt;
  logic [XLEN-1:0]    imem_rdata;
  // control flow change
  logic               redirect_valid;
  logic [XLEN-1:0]    redirect_pc;
  // register stage handshake
  logic               out_ready;
  logic               out_valid;
  logic [XLEN-1:0]    out_instr;
  logic [XLEN-1:0]    out_pc;
  logic [XLEN-1:0]    out_pc_plus_4;
  logic [c_occ_w-1:0] occupancy;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rdata,
    input  redirect_valid, redirect_pc,
    input  out_ready,
    output out_valid, out_instr, out_pc, out_pc_plus_4, occupancy
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rdata,
    output redirect_valid, redirect_pc,
    output out_ready,
    input  out_valid, out_instr, out_pc, out_pc_plus_4, occupancy
  );

endinterface
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Synchronous FIFO of fetch_entry_t with a flush that clears it
//               in one edge. Flush overrides push and pop; push while full is
//               accepted only together with a pop.
// Ports       : clk, rst         - clock, synchronous active-high reset
//               push, push_data  - write an entry at the tail
//               pop              - drop the head entry
//               flush            - discard every entry
//               full, empty      - status
//               count            - number of stored entries
//               head             - entry at the read pointer
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  wire logic                       clk,
  input  wire logic                       rst,
  input  wire logic                       push,
  input  wire fetch_entry_t               push_data,
  input  wire logic                       pop,
  input  wire logic                       flush,
  output logic                            full,
  output logic                            empty,
  output logic [$clog2(DEPTH+1)-1:0]      count,
  output fetch_entry_t                    head
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = $clog2(DEPTH + 1);

  fetch_entry_t       mem_q [DEPTH];
  logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d;
  logic [c_ptr_w-1:0] rd_ptr_q, rd_ptr_d;
  logic [c_cnt_w-1:0] count_q,  count_d;
  logic               do_push;
  logic               do_pop;

  always_comb begin
    do_pop   = pop & ~flush & (count_q != '0);
    // a full FIFO still takes a write when the head leaves in the same cycle
    do_push  = push & ~flush & ((count_q != c_cnt_w'(DEPTH)) | do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // pointers are log2(DEPTH) wide, so the increment wraps modulo DEPTH
      if (do_push) wr_ptr_d = wr_ptr_q + c_ptr_w'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + c_ptr_w'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + c_cnt_w'(1);
        2'b01:   count_d = count_q - c_cnt_w'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // storage needs no reset: an entry is only read after it was written
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  always_comb begin
    full  = (count_q == c_cnt_w'(DEPTH));
    empty = (count_q == '0);
    count = count_q;
    head  = mem_q[rd_ptr_q];
  end

endmodule
`default_nettype wire

// File: rtl/fetch_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_prefetch_queue
// Description : Instruction-fetch front end. Owns the fetch PC, requests the
//               shared memory port whenever there is room (or room is being
//               made this cycle), buffers up to DEPTH fetched instructions
//               and flushes on a redirect. Granted data reaches out_* one
//               cycle later; an empty queue presents NOP_INSTR.
// Ports       : clk   - clock
//               reset - synchronous, active-high
//               bus   - fetch_prefetch_queue_if.master (memory port,
//                       redirect, register-stage handshake, occupancy)
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_prefetch_queue
  import fetch_pkg::*;
#(
  parameter int              XLEN      = FETCH_XLEN,
  parameter int              DEPTH     = 4,
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  wire logic              clk,
  input  wire logic              reset,
  fetch_prefetch_queue_if.master bus
);

  localparam int c_cnt_w = $clog2(DEPTH + 1);

  logic [XLEN-1:0]    fetch_pc_q,      fetch_pc_d;
  // values shown while the queue is empty: the last head presented
  logic [XLEN-1:0]    last_pc_q,       last_pc_d;
  logic [XLEN-1:0]    last_pc_plus_4_q, last_pc_plus_4_d;

  fetch_entry_t       push_entry;
  fetch_entry_t       head_entry;
  logic               fifo_full;
  logic               fifo_empty;
  logic [c_cnt_w-1:0] fifo_count;
  logic               pop;
  logic               push;
  logic               req;

  always_comb begin
    pop  = ~fifo_empty & bus.out_ready & ~bus.redirect_valid;
    // combinational path from out_ready: a full queue refetches while it pops
    req  = ~reset & ~bus.redirect_valid & (~fifo_full | pop);
    push = req & bus.imem_gnt;

    push_entry.instr     = bus.imem_rdata;
    push_entry.pc        = fetch_pc_q;
    push_entry.pc_plus_4 = fetch_pc_q + XLEN'(4);

    fetch_pc_d = fetch_pc_q;
    if (bus.redirect_valid) begin
      fetch_pc_d = bus.redirect_pc & ~XLEN'(3);
    end else if (push) begin
      fetch_pc_d = push_entry.pc_plus_4;
    end

    last_pc_d        = last_pc_q;
    last_pc_plus_4_d = last_pc_plus_4_q;
    if (!fifo_empty) begin
      last_pc_d        = head_entry.pc;
      last_pc_plus_4_d = head_entry.pc_plus_4;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q       <= RESET_PC;
      last_pc_q        <= '0;
      last_pc_plus_4_q <= '0;
    end else begin
      fetch_pc_q       <= fetch_pc_d;
      last_pc_q        <= last_pc_d;
      last_pc_plus_4_q <= last_pc_plus_4_d;
    end
  end

  // redirect flushes; reset (rst) takes precedence inside the FIFO
  fetch_fifo #(
    .DEPTH     (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (bus.redirect_valid),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head      (head_entry)
  );

  always_comb begin
    bus.imem_req      = req;
    bus.imem_addr     = fetch_pc_q;
    bus.out_valid     = ~fifo_empty;
    bus.out_instr     = fifo_empty ? NOP_INSTR        : head_entry.instr;
    bus.out_pc        = fifo_empty ? last_pc_q        : head_entry.pc;
    bus.out_pc_plus_4 = fifo_empty ? last_pc_plus_4_q : head_entry.pc_plus_4;
    bus.occupancy     = fifo_count;
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_prefetch_queue
// Description : Directed bench for fetch_prefetch_queue (DEPTH = 4). Memory
//               returns 32'h1000_0000 + address. Inputs change 3 time units
//               after a rising edge; outputs are sampled away from the edge.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_prefetch_queue;

  localparam logic [31:0] c_nop = 32'h0000_0013;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  fetch_prefetch_queue_if #(.XLEN(32), .DEPTH(4)) bus ();

  fetch_prefetch_queue #(
    .XLEN      (32),
    .DEPTH     (4),
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (c_nop)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.imem_rdata = 32'h1000_0000 + bus.imem_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.imem_gnt       = 1'b0;
    bus.out_ready      = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;

    // ---- reset state
    tick();
    tick();
    chk("rst_req",   32'(bus.imem_req), 32'd0);
    chk("rst_occ",   32'(bus.occupancy), 32'd0);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_instr", bus.out_instr, c_nop);
    chk("rst_pc",    bus.out_pc, 32'h0);
    chk("rst_pc4",   bus.out_pc_plus_4, 32'h0);
    chk("rst_addr",  bus.imem_addr, 32'h0);

    // ---- fill with decode stalled
    reset = 1'b0; bus.imem_gnt = 1'b1; bus.out_ready = 1'b0;
    #1;
    chk("fill_req0", 32'(bus.imem_req), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("fill_occ",  32'(bus.occupancy), 32'(k));
      chk("fill_addr", bus.imem_addr, 32'(4 * k));
      chk("fill_pc",   bus.out_pc, 32'h0);
    end
    chk("full_req", 32'(bus.imem_req), 32'd0);
    tick();
    chk("full_occ",  32'(bus.occupancy), 32'd4);
    chk("full_addr", bus.imem_addr, 32'd16);
    chk("full_inst", bus.out_instr, 32'h1000_0000);

    // ---- release stall: push and pop together, no bubble
    bus.out_ready = 1'b1;
    #1;
    chk("pop_req_comb", 32'(bus.imem_req), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("drain_pc",   bus.out_pc, 32'(4 * k));
      chk("drain_occ",  32'(bus.occupancy), 32'd4);
      chk("drain_addr", bus.imem_addr, 32'(16 + 4 * k));
      chk("drain_inst", bus.out_instr, 32'h1000_0000 + 32'(4 * k));
    end

    // ---- one pop without grant: occupancy 3
    bus.imem_gnt = 1'b0;
    tick();
    chk("nogt_occ",  32'(bus.occupancy), 32'd3);
    chk("nogt_addr", bus.imem_addr, 32'd32);
    chk("nogt_pc",   bus.out_pc, 32'd20);

    // ---- redirect to a misaligned target
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0000_0102; bus.imem_gnt = 1'b1;
    #1;
    chk("redir_req", 32'(bus.imem_req), 32'd0);
    tick();
    chk("redir_occ",   32'(bus.occupancy), 32'd0);
    chk("redir_valid", 32'(bus.out_valid), 32'd0);
    chk("redir_instr", bus.out_instr, c_nop);
    chk("redir_addr",  bus.imem_addr, 32'h100);
    chk("redir_hold",  bus.out_pc, 32'd20);
    bus.redirect_valid = 1'b0;
    tick();
    chk("redir_pc",    bus.out_pc, 32'h100);
    chk("redir_pc4",   bus.out_pc_plus_4, 32'h104);
    chk("redir_inst",  bus.out_instr, 32'h1000_0100);
    chk("redir_occ1",  32'(bus.occupancy), 32'd1);

    // ---- grant withheld for 3 cycles: drain to empty
    bus.imem_gnt = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("wgt_occ",   32'(bus.occupancy), 32'd0);
      chk("wgt_instr", bus.out_instr, c_nop);
      chk("wgt_addr",  bus.imem_addr, 32'h104);
      chk("wgt_pc",    bus.out_pc, 32'h100);
    end
    bus.imem_gnt = 1'b1;
    tick();
    chk("resume_pc",   bus.out_pc, 32'h104);
    chk("resume_occ",  32'(bus.occupancy), 32'd1);
    chk("resume_addr", bus.imem_addr, 32'h108);

    // ---- reset mid-stream together with redirect
    bus.out_ready = 1'b0;
    tick();
    chk("pre_rst_occ", 32'(bus.occupancy), 32'd2);
    reset = 1'b1; bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0000_0200;
    #1;
    chk("mrst_req", 32'(bus.imem_req), 32'd0);
    tick();
    chk("mrst_occ",   32'(bus.occupancy), 32'd0);
    chk("mrst_addr",  bus.imem_addr, 32'h0);
    chk("mrst_valid", 32'(bus.out_valid), 32'd0);
    chk("mrst_instr", bus.out_instr, c_nop);
    chk("mrst_pc",    bus.out_pc, 32'h0);

    // ---- PC wrap-around at the top of the address space
    reset = 1'b0; bus.out_ready = 1'b1; bus.redirect_pc = 32'hFFFF_FFFB;
    tick();
    chk("wrap_addr0", bus.imem_addr, 32'hFFFF_FFF8);
    bus.redirect_valid = 1'b0;
    tick();
    chk("wrap_pc0",   bus.out_pc, 32'hFFFF_FFF8);
    chk("wrap_pc4_0", bus.out_pc_plus_4, 32'hFFFF_FFFC);
    chk("wrap_addr1", bus.imem_addr, 32'hFFFF_FFFC);
    tick();
    chk("wrap_pc1",   bus.out_pc, 32'hFFFF_FFFC);
    chk("wrap_pc4_1", bus.out_pc_plus_4, 32'h0);
    chk("wrap_addr2", bus.imem_addr, 32'h0);
    chk("wrap_inst",  bus.out_instr, 32'h0FFF_FFFC);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
